// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire routing cell.
package lif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInteg,
    StFire,
    StRefrac
  } lif_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int unsigned opp(input int unsigned k, input int unsigned n);
    return (k + n / 2) % n;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with synchronous reset to a fixed seed.
module lfsr8
  import lif_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LFSR_SEED;
    end else if (i_en) begin
      r_state <= {r_state[6:0], ^(r_state & LFSR_TAPS)};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lif_cell_n.sv
// N-channel leaky integrate-and-fire routing cell with head-on annihilation.
// Define LIF_CELL_LFSR_EN to steer side-only fires with a pseudo-random LFSR.
module lif_cell_n
  import lif_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned POT_W      = 8,
  parameter int unsigned THRESH     = 16,
  parameter int unsigned W_FACE     = 8,
  parameter int unsigned W_SIDE     = 3,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  i_in_face,
  input  logic [N_CH-1:0]  i_in_side,
  output logic [N_CH-1:0]  o_out_dir,
  output logic             o_fire,
  output logic             o_refrac,
  output logic [POT_W-1:0] o_pot
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned SUM_W = POT_W + $clog2(N_CH) + 4;
  localparam int unsigned CNT_W = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;
  localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'({POT_W{1'b1}});
  localparam logic [SUM_W-1:0] THR_L    = SUM_W'(THRESH);
  localparam logic [SUM_W-1:0] W_FACE_L = SUM_W'(W_FACE);
  localparam logic [SUM_W-1:0] W_SIDE_L = SUM_W'(W_SIDE);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((REFRAC_CYC > 0) ? REFRAC_CYC - 1 : 0);

  lif_state_e       r_state, w_state_nxt;
  logic [POT_W-1:0] r_pot, w_pot_nxt;
  logic [N_CH-1:0]  r_out_dir, w_out_dir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_lf_idx, w_lf_idx_nxt;
  logic             r_lf_vld, w_lf_vld_nxt;

  logic [N_CH-1:0]  w_face_masked;
  logic             w_face_any;
  logic [IDX_W-1:0] w_low_idx, w_fire_idx, w_tgt, w_side_idx;
  logic [N_CH-1:0]  w_dir_oh;
  logic [SUM_W-1:0] w_n_face, w_n_side, w_sum, w_sum_sat;
  logic [POT_W-1:0] w_leak;

  // A head-on pair cancels: drop both bits when the opposite channel also fires
  for (genvar k = 0; k < N_CH; k++) begin : g_mask
    localparam int unsigned OPP = opp(k, N_CH);
    assign w_face_masked[k] = i_in_face[k] & ~i_in_face[OPP];
  end

`ifdef LIF_CELL_LFSR_EN
  logic [7:0] w_lfsr;

  lfsr8 u_lfsr8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_side_idx = IDX_W'(32'(w_lfsr) % N_CH);
`else
  assign w_side_idx = '0;
`endif

  always_comb begin
    w_face_any = |w_face_masked;
    w_low_idx  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_face_masked[k]) w_low_idx = IDX_W'(k);
    end
    w_n_face = '0;
    w_n_side = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_n_face += SUM_W'(w_face_masked[k]);
      w_n_side += SUM_W'(i_in_side[k]);
    end
    w_leak = r_pot >> LEAK_SHIFT;
    if (r_pot != '0 && w_leak == '0) w_leak = POT_W'(1);
    w_sum     = SUM_W'(r_pot - w_leak) + W_FACE_L * w_n_face + W_SIDE_L * w_n_side;
    w_sum_sat = (w_sum > SUM_MAX) ? SUM_MAX : w_sum;
    // This cycle's own face input takes priority over the remembered one
    w_fire_idx = w_face_any ? w_low_idx : r_lf_idx;
    w_tgt      = (w_face_any || r_lf_vld) ? IDX_W'(opp(32'(w_fire_idx), N_CH)) : w_side_idx;
    w_dir_oh         = '0;
    w_dir_oh[w_tgt]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pot     <= '0;
      r_out_dir <= '0;
      r_cnt     <= '0;
      r_lf_idx  <= '0;
      r_lf_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pot     <= w_pot_nxt;
      r_out_dir <= w_out_dir_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lf_idx  <= w_lf_idx_nxt;
      r_lf_vld  <= w_lf_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pot_nxt     = r_pot;
    w_out_dir_nxt = '0;
    w_cnt_nxt     = r_cnt;
    w_lf_idx_nxt  = r_lf_idx;
    w_lf_vld_nxt  = r_lf_vld;
    unique case (r_state)
      StIdle, StInteg: begin
        if (w_face_any) begin
          w_lf_idx_nxt = w_low_idx;
          w_lf_vld_nxt = 1'b1;
        end
        if (w_sum_sat >= THR_L) begin
          w_state_nxt   = StFire;
          w_pot_nxt     = '0;
          w_out_dir_nxt = w_dir_oh;
          w_lf_idx_nxt  = '0;
          w_lf_vld_nxt  = 1'b0;
        end else begin
          w_pot_nxt   = w_sum_sat[POT_W-1:0];
          w_state_nxt = (w_sum_sat != '0) ? StInteg : StIdle;
        end
      end
      StFire: begin
        w_pot_nxt = '0;
        if (REFRAC_CYC > 0) begin
          w_state_nxt = StRefrac;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StRefrac: begin
        w_pot_nxt = '0;
        if (r_cnt == '0) w_state_nxt = StIdle;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_out_dir = r_out_dir;
    o_fire    = |r_out_dir;
    o_refrac  = (r_state == StFire) || (r_state == StRefrac);
    o_pot     = r_pot;
  end

endmodule

// File: tb/tb_lif_cell_n.sv
// Self-checking bench for lif_cell_n: directed scenarios plus randomized traffic vs. a model.
module tb_lif_cell_n;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int TH = 16;
  localparam int WF = 8;
  localparam int WS = 3;
  localparam int LS = 3;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  i_face = '0;
  logic [N-1:0]  i_side = '0;
  logic [N-1:0]  o_out_dir;
  logic          o_fire;
  logic          o_refrac;
  logic [PW-1:0] o_pot;

  int checks = 0;
  int errors = 0;

  lif_cell_n #(
    .N_CH       (N),
    .POT_W      (PW),
    .THRESH     (TH),
    .W_FACE     (WF),
    .W_SIDE     (WS),
    .LEAK_SHIFT (LS),
    .REFRAC_CYC (RC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in_face (i_face),
    .i_in_side (i_side),
    .o_out_dir (o_out_dir),
    .o_fire    (o_fire),
    .o_refrac  (o_refrac),
    .o_pot     (o_pot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] f, input logic [N-1:0] s, input logic r);
    i_face = f;
    i_side = s;
    rst_n  = r;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: potential as an integer, "hold" counts input-ignoring cycles left
  int           m_pot;
  int           m_hold;
  int           m_last;
  logic [N-1:0] m_dir;
  bit           m_refrac;
  bit           m_known = 1'b0;
  logic [7:0]   m_lfsr;

  initial begin
    int nf, ns, lowest, leak, sum, tgt;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pot = 0; m_hold = 0; m_last = -1; m_dir = '0; m_refrac = 1'b0;
        m_lfsr = 8'hA5; m_known = 1'b1;
      end else if (m_known) begin
        if (m_hold > 0) begin
          m_hold--;
          m_pot = 0;
          m_dir = '0;
          m_refrac = (m_hold > 0);
        end else begin
          nf = 0; lowest = -1;
          for (int k = 0; k < N; k++) begin
            if (i_face[k] && !i_face[(k + N / 2) % N]) begin
              nf++;
              if (lowest < 0) lowest = k;
            end
          end
          ns = $countones(i_side);
          leak = m_pot >> LS;
          if (m_pot != 0 && leak == 0) leak = 1;
          sum = m_pot - leak + WF * nf + WS * ns;
          if (sum > (1 << PW) - 1) sum = (1 << PW) - 1;
          if (lowest >= 0) m_last = lowest;
          if (sum >= TH) begin
`ifdef LIF_CELL_LFSR_EN
            tgt = (m_last >= 0) ? (m_last + N / 2) % N : int'(m_lfsr) % N;
`else
            tgt = (m_last >= 0) ? (m_last + N / 2) % N : 0;
`endif
            m_dir = N'(1) << tgt;
            m_pot = 0; m_last = -1; m_hold = 1 + RC; m_refrac = 1'b1;
          end else begin
            m_pot = sum; m_dir = '0; m_refrac = 1'b0;
          end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("pot", 32'(o_pot), 32'(m_pot));
        chk("out_dir", 32'(o_out_dir), 32'(m_dir));
        chk("fire", 32'(o_fire), 32'(|m_dir));
        chk("refrac", 32'(o_refrac), 32'(m_refrac));
      end
    end
  end

  initial begin
    // Reset with random inputs
    step(N'($urandom), N'($urandom), 1'b0);
    step(N'($urandom), N'($urandom), 1'b0);
    chk("rst_pot", 32'(o_pot), 0);
    chk("rst_dir", 32'(o_out_dir), 0);
    chk("rst_fire", 32'(o_fire), 0);
    chk("rst_refrac", 32'(o_refrac), 0);

    // Pass-through integrate and fire
    step(4'b0001, '0, 1'b1); chk("pt_pot1", 32'(o_pot), 8);
    step(4'b0001, '0, 1'b1); chk("pt_pot2", 32'(o_pot), 15);
    step(4'b0001, '0, 1'b1);
    chk("pt_fire", 32'(o_fire), 1);
    chk("pt_dir", 32'(o_out_dir), 32'b0100);
    chk("pt_pot3", 32'(o_pot), 0);
    chk("pt_refrac", 32'(o_refrac), 1);

    // Refractory: inputs ignored for 3 edges after the fire
    step(4'b1000, '0, 1'b1); chk("rf_r1", 32'(o_refrac), 1); chk("rf_p1", 32'(o_pot), 0);
    step(4'b1000, '0, 1'b1); chk("rf_r2", 32'(o_refrac), 1); chk("rf_p2", 32'(o_pot), 0);
    step(4'b1000, '0, 1'b1); chk("rf_r3", 32'(o_refrac), 0); chk("rf_p3", 32'(o_pot), 0);
    step(4'b1000, '0, 1'b1); chk("rf_resume", 32'(o_pot), 8);

    // Annihilation, then last_face=1 steers a side-driven fire to channel 3
    step('0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0101, '0, 1'b1);
      chk("an_pot", 32'(o_pot), 0);
      chk("an_fire", 32'(o_fire), 0);
    end
    step(4'b0111, '0, 1'b1); chk("an_pot8", 32'(o_pot), 8);
    step('0, 4'b1111, 1'b1); chk("an_dir", 32'(o_out_dir), 32'b1000);

    // Leak to zero
    step('0, '0, 1'b0);
    step(4'b0010, '0, 1'b1); chk("lk_pot8", 32'(o_pot), 8);
    for (int i = 1; i <= 8; i++) begin
      step('0, '0, 1'b1);
      chk("lk_pot", 32'(o_pot), 32'(8 - i));
    end

    // Side-only fire
    step('0, '0, 1'b0);
    step('0, 4'b1111, 1'b1); chk("sd_pot12", 32'(o_pot), 12);
    step('0, 4'b1111, 1'b1); chk("sd_fire", 32'(o_fire), 1);
`ifndef LIF_CELL_LFSR_EN
    chk("sd_dir", 32'(o_out_dir), 32'b0001);
`endif

    // Reset during refractory
    step('0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, '0, 1'b1);
    step('0, '0, 1'b1); chk("mr_in_refrac", 32'(o_refrac), 1);
    step('0, '0, 1'b0);
    chk("mr_refrac", 32'(o_refrac), 0);
    chk("mr_fire", 32'(o_fire), 0);
    step(4'b0001, '0, 1'b1); chk("mr_accept", 32'(o_pot), 8);

    // Randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      step(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
           ($urandom_range(0, 63) != 0));
    end
    step('0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
